// File: rtl/dsnk_arb.sv
// dsnk_arb: packet-granular round-robin AXI-Stream arbiter in front of one dsnk sink.
// N_PORTS sources share the dsnk engine; a grant is held from first beat through TLAST,
// with one idle cycle between packets.
// Optional build macro: DSNK_ARB_STATS_EN adds per-port completed-packet counters
// (pkt_cnt output, stat_clr input). Without it arbitration is identical.

// Per-port slice: request qualification, ready steering and optional packet counter.
module dsnk_arb_port (
`ifdef DSNK_ARB_STATS_EN
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tlast_i,
  input  logic        stat_clr_i,
  output logic [31:0] cnt_o,
`endif
  input  logic        tvalid_i,
  input  logic        en_i,
  input  logic        sel_i,      // this port owns the grant and a packet is in progress
  input  logic        m_tready_i,
  output logic        req_o,
  output logic        tready_o
);

  // port_en only qualifies new requests; an owned packet ignores it
  assign req_o    = tvalid_i & en_i;
  assign tready_o = sel_i & m_tready_i;

`ifdef DSNK_ARB_STATS_EN
  logic [31:0] cnt_q;

  // count completed packets; clear wins over a coincident TLAST handshake
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      cnt_q <= '0;
    else if (stat_clr_i)                            cnt_q <= '0;
    else if (sel_i & tvalid_i & m_tready_i & tlast_i) cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

module dsnk_arb #(
  parameter int N_PORTS                  = 4,
  parameter int C_S_AXIS_TDATA_NUM_BYTES = 4
) (
  input  logic                                    AXIS_ACLK,
  input  logic                                    AXIS_ARESET,
  input  logic [N_PORTS-1:0]                      port_en,
  input  logic [N_PORTS-1:0]                      S_AXIS_TVALID,
  output logic [N_PORTS-1:0]                      S_AXIS_TREADY,
  input  logic [N_PORTS*C_S_AXIS_TDATA_NUM_BYTES*8-1:0] S_AXIS_TDATA,
  input  logic [N_PORTS*C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic [N_PORTS-1:0]                      S_AXIS_TLAST,
  output logic                                    M_AXIS_TVALID,
  input  logic                                    M_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_NUM_BYTES*8-1:0]   M_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
  output logic                                    M_AXIS_TLAST,
  output logic [$clog2(N_PORTS)-1:0]              grant_id,
`ifdef DSNK_ARB_STATS_EN
  output logic [N_PORTS*32-1:0]                   pkt_cnt,
  input  logic                                    stat_clr,
`endif
  output logic                                    busy
);

  localparam int B   = C_S_AXIS_TDATA_NUM_BYTES;
  localparam int DW  = B * 8;
  localparam int IDW = $clog2(N_PORTS);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q;
  logic [IDW-1:0]     grant_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic               busy_q;

  logic [N_PORTS-1:0] req;
  logic [IDW-1:0]     cand [N_PORTS];
  logic               win_vld;
  logic [IDW-1:0]     win_id;
  logic               last_hs;

  // per-port slices
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    dsnk_arb_port u_port (
`ifdef DSNK_ARB_STATS_EN
      .clk_i      (AXIS_ACLK),
      .rst_i      (AXIS_ARESET),
      .tlast_i    (S_AXIS_TLAST[i]),
      .stat_clr_i (stat_clr),
      .cnt_o      (pkt_cnt[i*32 +: 32]),
`endif
      .tvalid_i   (S_AXIS_TVALID[i]),
      .en_i       (port_en[i]),
      .sel_i      (busy_q && (grant_q == IDW'(i))),
      .m_tready_i (M_AXIS_TREADY),
      .req_o      (req[i]),
      .tready_o   (S_AXIS_TREADY[i])
    );
  end

  // scan order rr_ptr+1, rr_ptr+2, ... wrapping mod N_PORTS; last entry is rr_ptr itself,
  // so a sole requester wins again. Candidates never reach indices >= N_PORTS.
  for (genvar k = 0; k < N_PORTS; k++) begin : g_cand
    assign cand[k] = IDW'((int'(rr_ptr_q) + k + 1) % N_PORTS);
  end

  // first requester in rotating order
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!win_vld && req[cand[k]]) begin
        win_vld = 1'b1;
        win_id  = cand[k];
      end
    end
  end

  // combinational pass-through of the granted port; data muxes follow grant_id always
  assign M_AXIS_TVALID = busy_q & S_AXIS_TVALID[grant_q];
  assign M_AXIS_TDATA  = S_AXIS_TDATA[int'(grant_q)*DW +: DW];
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB[int'(grant_q)*B +: B];
  assign M_AXIS_TLAST  = S_AXIS_TLAST[grant_q];
  assign last_hs       = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

  // arbitration FSM: grant in IDLE, hold until the TLAST handshake, then one idle bubble
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(N_PORTS - 1);
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            grant_q  <= win_id;
            rr_ptr_q <= win_id;
            busy_q   <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (last_hs) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dsnk_arb.sv
// Directed bench for dsnk_arb (N_PORTS=4, 4-byte beats).
// Source model: port p, packet k, beat b carries data {p,k,0x10+b}, strobe p+1.
module tb_dsnk_arb;
  localparam int N  = 4;
  localparam int B  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      port_en, s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0]   s_tdata;
  logic [N*B-1:0]    s_tstrb;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [B-1:0]      m_tstrb;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef DSNK_ARB_STATS_EN
  logic [N*32-1:0]   pkt_cnt;
  logic              stat_clr = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  int npk[N], len[N], beat[N], pktno[N];

  always #5 clk = ~clk;

  dsnk_arb #(.N_PORTS(N), .C_S_AXIS_TDATA_NUM_BYTES(B)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .port_en       (port_en),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .grant_id      (grant_id),
`ifdef DSNK_ARB_STATS_EN
    .pkt_cnt       (pkt_cnt),
    .stat_clr      (stat_clr),
`endif
    .busy          (busy)
  );

  function automatic logic [31:0] exp_data(int p, int k, int b);
    return 32'((p << 12) | (k << 8) | (16 + b));
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]           = npk[i] > 0;
      s_tlast[i]            = beat[i] == len[i] - 1;
      s_tdata[i*DW +: DW]   = exp_data(i, pktno[i], beat[i]);
      s_tstrb[i*B +: B]     = 4'(i + 1);
    end
  endtask

  // one clock: sample handshakes just before the edge, advance sources after it
  task automatic tick();
    logic [N-1:0] hs;
    #2;
    hs = s_tready & s_tvalid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pktno[i]++;
          npk[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic setup(int p, int n, int l);
    npk[p] = n; len[p] = l; beat[p] = 0; pktno[p] = 0;
    drive_src();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      npk[i] = 0; len[i] = 1; beat[i] = 0; pktno[i] = 0;
    end
    drive_src();
    #1;
  endtask

  // expects the FSM to be BUSY on port p at beat b0; walks to TLAST and the idle bubble
  task automatic expect_pkt(int p, int n, int k, int b0);
    for (int b = b0; b < n; b++) begin
      chk($sformatf("p%0d k%0d b%0d busy", p, k, b), 64'(busy), 64'(1));
      chk($sformatf("p%0d k%0d b%0d grant", p, k, b), 64'(grant_id), 64'(p));
      chk($sformatf("p%0d k%0d b%0d mvalid", p, k, b), 64'(m_tvalid), 64'(1));
      chk($sformatf("p%0d k%0d b%0d mdata", p, k, b), 64'(m_tdata), 64'(exp_data(p, k, b)));
      chk($sformatf("p%0d k%0d b%0d mstrb", p, k, b), 64'(m_tstrb), 64'(p + 1));
      chk($sformatf("p%0d k%0d b%0d mlast", p, k, b), 64'(m_tlast), 64'(b == n - 1));
      chk($sformatf("p%0d k%0d b%0d sready", p, k, b), 64'(s_tready), 64'(1 << p));
      tick();
    end
    chk($sformatf("p%0d k%0d bubble busy", p, k), 64'(busy), 64'(0));
    chk($sformatf("p%0d k%0d bubble mvalid", p, k), 64'(m_tvalid), 64'(0));
    chk($sformatf("p%0d k%0d bubble sready", p, k), 64'(s_tready), 64'(0));
  endtask

  initial begin
    rst = 1'b1; port_en = '1; m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      npk[i] = 0; len[i] = 1; beat[i] = 0; pktno[i] = 0;
    end
    drive_src();

    // 1: reset values, then a 4-beat packet on port 0
    do_reset();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst grant", 64'(grant_id), 64'(0));
    chk("rst mvalid", 64'(m_tvalid), 64'(0));
    chk("rst sready", 64'(s_tready), 64'(0));
    chk("rst mdata follows grant", 64'(m_tdata), 64'(32'h10));
    setup(0, 1, 4);
    chk("t1 idle mvalid", 64'(m_tvalid), 64'(0));
    tick();
    expect_pkt(0, 4, 0, 0);
    tick();
    chk("t1 stays idle", 64'(busy), 64'(0));

    // 2: all ports request, round-robin 0,1,2,3,0
    do_reset();
    setup(0, 2, 2); setup(1, 1, 2); setup(2, 1, 2); setup(3, 1, 2);
    tick(); expect_pkt(0, 2, 0, 0);
    tick(); expect_pkt(1, 2, 0, 0);
    tick(); expect_pkt(2, 2, 0, 0);
    tick(); expect_pkt(3, 2, 0, 0);
    tick(); expect_pkt(0, 2, 1, 0);
    tick();
    chk("t2 drained", 64'(busy), 64'(0));

    // 3: only ports 1 and 3 enabled, they alternate
    do_reset();
    port_en = 4'b1010;
    setup(0, 2, 1); setup(1, 2, 1); setup(2, 2, 1); setup(3, 2, 1);
    tick(); expect_pkt(1, 1, 0, 0);
    tick(); expect_pkt(3, 1, 0, 0);
    tick(); expect_pkt(1, 1, 1, 0);
    tick(); expect_pkt(3, 1, 1, 0);
    tick();
    chk("t3 disabled never granted", 64'(busy), 64'(0));
    chk("t3 disabled sready", 64'(s_tready), 64'(0));

    // 4: downstream stall in the middle of a port 2 packet
    do_reset();
    port_en = '1;
    setup(2, 1, 4); setup(3, 1, 1);
    tick();
    chk("t4 grant", 64'(grant_id), 64'(2));
    chk("t4 beat0", 64'(m_tdata), 64'(exp_data(2, 0, 0)));
    tick();
    m_tready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4 stall%0d mdata", c), 64'(m_tdata), 64'(exp_data(2, 0, 1)));
      chk($sformatf("t4 stall%0d mvalid", c), 64'(m_tvalid), 64'(1));
      chk($sformatf("t4 stall%0d sready", c), 64'(s_tready), 64'(0));
      chk($sformatf("t4 stall%0d grant", c), 64'(grant_id), 64'(2));
      tick();
    end
    m_tready = 1'b1;
    #1;
    expect_pkt(2, 4, 0, 1);
    tick(); expect_pkt(3, 1, 0, 0);

    // 5: port_en dropped mid-packet, then sole requester re-wins, then reset mid-packet
    do_reset();
    setup(1, 2, 4);
    tick();
    chk("t5 grant", 64'(grant_id), 64'(1));
    tick();
    port_en[1] = 1'b0;
    #1;
    expect_pkt(1, 4, 0, 1);
    tick();
    chk("t5 no regrant", 64'(busy), 64'(0));
    tick();
    chk("t5 no regrant 2", 64'(busy), 64'(0));
    port_en[1] = 1'b1;
    #1;
    tick();
    chk("t5 rewin busy", 64'(busy), 64'(1));
    chk("t5 rewin grant", 64'(grant_id), 64'(1));
    chk("t5 rewin data", 64'(m_tdata), 64'(exp_data(1, 1, 0)));
    tick();
    rst = 1'b1;
    tick();
    chk("t5 midrst busy", 64'(busy), 64'(0));
    chk("t5 midrst mvalid", 64'(m_tvalid), 64'(0));
    chk("t5 midrst sready", 64'(s_tready), 64'(0));
    chk("t5 midrst grant", 64'(grant_id), 64'(0));
    rst = 1'b0;

`ifdef DSNK_ARB_STATS_EN
    // 6: packet counters and clear priority
    do_reset();
    setup(0, 3, 1); setup(3, 1, 1);
    for (int c = 0; c < 12; c++) tick();
    chk("t6 idle", 64'(busy), 64'(0));
    chk("t6 cnt0", 64'(pkt_cnt[0 +: 32]), 64'(3));
    chk("t6 cnt1", 64'(pkt_cnt[32 +: 32]), 64'(0));
    chk("t6 cnt3", 64'(pkt_cnt[96 +: 32]), 64'(1));
    setup(0, 1, 2);
    tick();
    tick();
    stat_clr = 1'b1;
    #1;
    chk("t6 last beat", 64'(m_tlast), 64'(1));
    tick();
    stat_clr = 1'b0;
    chk("t6 clr cnt0", 64'(pkt_cnt[0 +: 32]), 64'(0));
    chk("t6 clr cnt3", 64'(pkt_cnt[96 +: 32]), 64'(0));
    chk("t6 clr busy", 64'(busy), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
